// File: rtl/gearbox_rx.sv
// Receive 64b->66b gearbox with a single-bit slip for block-lock hunting.
// Zero-cycle latency: a block completed by the current word is presented combinationally; no backpressure.
module gearbox_rx #(
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              lock_v_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              slip_v_i,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int BLK_W = DATA_W + HEAD_W;
  localparam int BUF_W = BLK_W - 1;
  localparam int CAT_W = DATA_W + BUF_W;
  localparam int LEN_W = $clog2(BUF_W + 1);

  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] buf_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic [BUF_W-1:0] buf_mask;
  logic [CAT_W-1:0] cat;

  // At len_q == BUF_W the shifted one falls off the top, leaving an all-ones mask.
  assign buf_mask = (BUF_W'(1) << len_q) - BUF_W'(1);
  assign cat      = (CAT_W'(data_i) << len_q) | CAT_W'(buf_q & buf_mask);

  assign {data_o, head_o} = cat[BLK_W-1:0];
  assign valid_o = !nreset && lock_v_i && !slip_v_i && (len_q >= LEN_W'(HEAD_W));

  always_comb begin
    buf_d = buf_q;
    len_d = len_q;
    if (!lock_v_i) begin
      buf_d = '0;
      len_d = '0;
    end else if (slip_v_i) begin
      // A slip with bits buffered throws away the whole incoming word as well.
      if (len_q != '0) begin
        buf_d = buf_q >> 1;
        len_d = len_q - LEN_W'(1);
      end else begin
        buf_d = BUF_W'(data_i >> 1);
        len_d = LEN_W'(DATA_W - 1);
      end
    end else if (len_q >= LEN_W'(HEAD_W)) begin
      buf_d = {{HEAD_W{1'b0}}, cat[CAT_W-1:BLK_W]};
      len_d = len_q - LEN_W'(HEAD_W);
    end else begin
      buf_d = cat[BUF_W-1:0];
      len_d = len_q + LEN_W'(DATA_W);
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      buf_q <= '0;
      len_q <= '0;
    end else begin
      buf_q <= buf_d;
      len_q <= len_d;
    end
  end

endmodule

// File: tb/tb_gearbox_rx.sv
// Bench for gearbox_rx: serial bit-stream model feeding 64b words, block scoreboard on the output.
module tb_gearbox_rx;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        lock_v_i = 1'b0;
  logic        slip_v_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        valid_o;
  logic [1:0]  head_o;
  logic [63:0] data_o;

  int tests = 0;
  int fails = 0;

  bit          stream_q[$];
  logic [65:0] exp_q[$];

  always #5 clk = ~clk;

  gearbox_rx #(.HEAD_W(2), .DATA_W(64)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .lock_v_i (lock_v_i),
    .data_i   (data_i),
    .slip_v_i (slip_v_i),
    .valid_o  (valid_o),
    .head_o   (head_o),
    .data_o   (data_o)
  );

  task automatic drive(input logic rst, input logic lk, input logic sl, input logic [63:0] w);
    @(posedge clk);
    #1;
    nreset   = rst;
    lock_v_i = lk;
    slip_v_i = sl;
    data_i   = w;
    @(negedge clk);
  endtask

  task automatic push_block(input logic [1:0] h, input logic [63:0] d);
    logic [65:0] blk;
    blk = {d, h};
    for (int i = 0; i < 66; i++) stream_q.push_back(blk[i]);
    exp_q.push_back(blk);
  endtask

  task automatic next_word(output logic [63:0] w);
    w = '0;
    for (int i = 0; i < 64; i++)
      if (stream_q.size() > 0) w[i] = stream_q.pop_front();
  endtask

  task automatic clear_q();
    stream_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic test_reset();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    drive(1'b1, 1'b1, 1'b1, w);
    drive(1'b1, 1'b1, 1'b1, w);
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got=%b exp=0", valid_o);
    end
    tests++;
    if ({data_o, head_o} !== {2'b00, w}) begin
      fails++;
      $display("FAIL reset_cat got=%h exp=%h", {data_o, head_o}, {2'b00, w});
    end
    w = {$urandom(), $urandom()};
    drive(1'b0, 1'b1, 1'b0, w);
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL first_lock_valid got=%b exp=0", valid_o);
    end
  endtask

  task automatic test_const_stream();
    logic [63:0] w;
    logic        ev;
    do_reset();
    clear_q();
    for (int i = 0; i < 75; i++) push_block(2'b01, 64'hAAAA_AAAA_AAAA_AAAA);
    for (int c = 0; c < 70; c++) begin
      next_word(w);
      drive(1'b0, 1'b1, 1'b0, w);
      ev = (c % 33) != 0;
      tests++;
      if (valid_o !== ev) begin
        fails++;
        $display("FAIL const_valid cyc=%0d got=%b exp=%b", c, valid_o, ev);
      end
      if (valid_o === 1'b1) begin
        tests++;
        if (head_o !== 2'b01 || data_o !== 64'hAAAA_AAAA_AAAA_AAAA) begin
          fails++;
          $display("FAIL const_blk cyc=%0d got=%h_%b exp=aaaaaaaaaaaaaaaa_01", c, data_o, head_o);
        end
      end
    end
  endtask

  task automatic test_random_blocks();
    logic [63:0] w;
    logic [65:0] e;
    logic        ev;
    int          nv;
    do_reset();
    clear_q();
    nv = 0;
    for (int i = 0; i < 330; i++) push_block(2'($urandom()), {$urandom(), $urandom()});
    for (int c = 0; c < 330; c++) begin
      next_word(w);
      drive(1'b0, 1'b1, 1'b0, w);
      ev = (c % 33) != 0;
      tests++;
      if (valid_o !== ev) begin
        fails++;
        $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, valid_o, ev);
      end
      if (valid_o === 1'b1) begin
        nv++;
        e = exp_q.pop_front();
        tests++;
        if ({data_o, head_o} !== e) begin
          fails++;
          $display("FAIL rand_blk cyc=%0d got=%h exp=%h", c, {data_o, head_o}, e);
        end
      end
    end
    tests++;
    if (nv != 320) begin
      fails++;
      $display("FAIL rand_count got=%0d exp=320", nv);
    end
  endtask

  task automatic test_lock_drop();
    logic [63:0] w;
    logic [65:0] e;
    logic        ev;
    do_reset();
    clear_q();
    for (int i = 0; i < 20; i++) push_block(2'($urandom()), {$urandom(), $urandom()});
    for (int c = 0; c < 10; c++) begin
      next_word(w);
      drive(1'b0, 1'b1, 1'b0, w);
      ev = (c % 33) != 0;
      tests++;
      if (valid_o !== ev) begin
        fails++;
        $display("FAIL drop_pre_valid cyc=%0d got=%b exp=%b", c, valid_o, ev);
      end
      if (valid_o === 1'b1) begin
        e = exp_q.pop_front();
        tests++;
        if ({data_o, head_o} !== e) begin
          fails++;
          $display("FAIL drop_pre_blk cyc=%0d got=%h exp=%h", c, {data_o, head_o}, e);
        end
      end
    end
    for (int c = 10; c < 13; c++) begin
      drive(1'b0, 1'b0, 1'($urandom()), {$urandom(), $urandom()});
      tests++;
      if (valid_o !== 1'b0) begin
        fails++;
        $display("FAIL drop_low_valid cyc=%0d got=%b exp=0", c, valid_o);
      end
    end
    clear_q();
    for (int i = 0; i < 40; i++) push_block(2'($urandom()), {$urandom(), $urandom()});
    for (int c = 0; c < 40; c++) begin
      next_word(w);
      drive(1'b0, 1'b1, 1'b0, w);
      ev = (c % 33) != 0;
      tests++;
      if (valid_o !== ev) begin
        fails++;
        $display("FAIL drop_post_valid cyc=%0d got=%b exp=%b", c, valid_o, ev);
      end
      if (valid_o === 1'b1) begin
        e = exp_q.pop_front();
        tests++;
        if ({data_o, head_o} !== e) begin
          fails++;
          $display("FAIL drop_post_blk cyc=%0d got=%h exp=%h", c, {data_o, head_o}, e);
        end
      end
    end
  endtask

  // True blocks start 61 bits in; five slips (65 bits each) reach that phase.
  // The first post-slip block straddles the splice, so only its header is predictable.
  task automatic test_slip_hunt();
    logic [63:0] w;
    logic [65:0] e;
    bit          first;
    int          nv;
    do_reset();
    clear_q();
    for (int i = 0; i < 61; i++)
      stream_q.push_back((i == 5) ? 1'b1 : (i == 6) ? 1'b0 : 1'($urandom()));
    for (int i = 0; i < 70; i++) push_block(2'b01, {$urandom(), $urandom()});
    next_word(w);
    drive(1'b0, 1'b1, 1'b0, w);
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL hunt_idle_valid got=%b exp=0", valid_o);
    end
    for (int c = 1; c <= 5; c++) begin
      next_word(w);
      drive(1'b0, 1'b1, 1'b1, w);
      tests++;
      if (valid_o !== 1'b0) begin
        fails++;
        $display("FAIL hunt_slip_valid cyc=%0d got=%b exp=0", c, valid_o);
      end
    end
    for (int i = 0; i < 5; i++) void'(exp_q.pop_front());
    first = 1'b1;
    nv = 0;
    for (int c = 6; c < 66; c++) begin
      next_word(w);
      drive(1'b0, 1'b1, 1'b0, w);
      if (valid_o === 1'b1) begin
        nv++;
        tests++;
        if (head_o !== 2'b01) begin
          fails++;
          $display("FAIL hunt_head cyc=%0d got=%b exp=01", c, head_o);
        end
        if (!first) begin
          e = exp_q.pop_front();
          tests++;
          if ({data_o, head_o} !== e) begin
            fails++;
            $display("FAIL hunt_blk cyc=%0d got=%h exp=%h", c, {data_o, head_o}, e);
          end
        end
        first = 1'b0;
      end
    end
    tests++;
    if (nv != 59) begin
      fails++;
      $display("FAIL hunt_count got=%0d exp=59", nv);
    end
  endtask

  task automatic test_slip_zero();
    logic [63:0] w;
    logic [65:0] e;
    int          nv;
    do_reset();
    clear_q();
    stream_q.push_back(1'($urandom()));
    for (int i = 0; i < 45; i++) push_block(2'($urandom()), {$urandom(), $urandom()});
    next_word(w);
    drive(1'b0, 1'b1, 1'b1, w);
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL slip0_valid got=%b exp=0", valid_o);
    end
    nv = 0;
    for (int c = 1; c <= 40; c++) begin
      next_word(w);
      drive(1'b0, 1'b1, 1'b0, w);
      if (c == 1) begin
        tests++;
        if (valid_o !== 1'b1) begin
          fails++;
          $display("FAIL slip0_resume got=%b exp=1", valid_o);
        end
      end
      if (valid_o === 1'b1) begin
        nv++;
        e = exp_q.pop_front();
        tests++;
        if ({data_o, head_o} !== e) begin
          fails++;
          $display("FAIL slip0_blk cyc=%0d got=%h exp=%h", c, {data_o, head_o}, e);
        end
      end
    end
    tests++;
    if (nv != 39) begin
      fails++;
      $display("FAIL slip0_count got=%0d exp=39", nv);
    end
  endtask

  task automatic test_reset_priority();
    logic [63:0] w;
    logic [65:0] e;
    logic        ev;
    do_reset();
    clear_q();
    for (int i = 0; i < 10; i++) push_block(2'($urandom()), {$urandom(), $urandom()});
    for (int c = 0; c < 5; c++) begin
      next_word(w);
      drive(1'b0, 1'b1, 1'b0, w);
    end
    drive(1'b1, 1'b1, 1'b1, {$urandom(), $urandom()});
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL rstpri_valid got=%b exp=0", valid_o);
    end
    clear_q();
    for (int i = 0; i < 40; i++) push_block(2'($urandom()), {$urandom(), $urandom()});
    for (int c = 0; c < 34; c++) begin
      next_word(w);
      drive(1'b0, 1'b1, 1'b0, w);
      ev = (c % 33) != 0;
      tests++;
      if (valid_o !== ev) begin
        fails++;
        $display("FAIL rstpri_post_valid cyc=%0d got=%b exp=%b", c, valid_o, ev);
      end
      if (valid_o === 1'b1) begin
        e = exp_q.pop_front();
        tests++;
        if ({data_o, head_o} !== e) begin
          fails++;
          $display("FAIL rstpri_blk cyc=%0d got=%h exp=%h", c, {data_o, head_o}, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_const_stream();
    test_random_blocks();
    test_lock_drop();
    test_slip_hunt();
    test_slip_zero();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
